// File: rtl/multiply_shift_add_if.sv
// Operand/result bundle between the complement stage, the multiplier and the
// result/display stage.
interface multiply_shift_add_if;
  logic [3:0] first_nr;
  logic [3:0] second_nr;
  logic       complement1_finish;
  logic [7:0] product;
  logic       mult_finish;
  logic       busy;

  modport master (
    output first_nr,
    output second_nr,
    output complement1_finish,
    input  product,
    input  mult_finish,
    input  busy
  );

  modport slave (
    input  first_nr,
    input  second_nr,
    input  complement1_finish,
    output product,
    output mult_finish,
    output busy
  );
endinterface

// File: rtl/multiply_shift_add.sv
// Sequential signed 4x4 shift-and-add multiplier. Starts on the rising edge of
// complement1_finish, produces an 8-bit signed product four cycles later.
module multiply_shift_add (
  input  logic                       clk,
  input  logic                       rst,
  multiply_shift_add_if.slave        bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t     state;
  state_t     state_nxt;
  logic       fin_d;
  logic [7:0] m;
  logic [7:0] m_nxt;
  logic [3:0] b;
  logic [3:0] b_nxt;
  logic [7:0] acc;
  logic [7:0] acc_nxt;
  logic [1:0] step;
  logic [1:0] step_nxt;
  logic [7:0] product;
  logic [7:0] product_nxt;
  logic       mult_finish;
  logic       mult_finish_nxt;
  logic       busy;
  logic       busy_nxt;
  logic       start;
  logic [7:0] acc_step;

  // One partial-product step; the multiplier sign bit (step 3) carries weight -8.
  function automatic logic [7:0] partial_sum(
    input logic [7:0] acc_in,
    input logic [7:0] mcand,
    input logic [3:0] mplier,
    input logic [1:0] idx
  );
    logic [7:0] addend;
    addend = mcand << idx;
    if (!mplier[idx]) begin
      partial_sum = acc_in;
    end else if (idx == 2'd3) begin
      partial_sum = acc_in - addend;
    end else begin
      partial_sum = acc_in + addend;
    end
  endfunction

  assign start    = bus.complement1_finish & ~fin_d;
  assign acc_step = partial_sum(acc, m, b, step);

  // Next-state and datapath update; only IDLE/DONE accept a start edge.
  always_comb begin
    state_nxt       = state;
    m_nxt           = m;
    b_nxt           = b;
    acc_nxt         = acc;
    step_nxt        = step;
    product_nxt     = product;
    mult_finish_nxt = mult_finish;
    busy_nxt        = busy;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          state_nxt       = CALC;
          m_nxt           = {{4{bus.first_nr[3]}}, bus.first_nr};
          b_nxt           = bus.second_nr;
          acc_nxt         = 8'h00;
          step_nxt        = 2'd0;
          mult_finish_nxt = 1'b0;
          busy_nxt        = 1'b1;
        end else begin
          state_nxt = state;
        end
      end
      CALC: begin
        acc_nxt = acc_step;
        if (step == 2'd3) begin
          state_nxt       = DONE;
          product_nxt     = acc_step;
          mult_finish_nxt = 1'b1;
          busy_nxt        = 1'b0;
        end else begin
          step_nxt = step + 2'd1;
        end
      end
      default: begin
        state_nxt       = IDLE;
        mult_finish_nxt = 1'b0;
        busy_nxt        = 1'b0;
      end
    endcase
  end

  // State, operand and result registers; reset discards any partial result.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      fin_d       <= 1'b0;
      m           <= 8'h00;
      b           <= 4'h0;
      acc         <= 8'h00;
      step        <= 2'd0;
      product     <= 8'h00;
      mult_finish <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state       <= state_nxt;
      fin_d       <= bus.complement1_finish;
      m           <= m_nxt;
      b           <= b_nxt;
      acc         <= acc_nxt;
      step        <= step_nxt;
      product     <= product_nxt;
      mult_finish <= mult_finish_nxt;
      busy        <= busy_nxt;
    end
  end

  assign bus.product     = product;
  assign bus.mult_finish = mult_finish;
  assign bus.busy        = busy;

endmodule

// File: tb/tb_multiply_shift_add.sv
// Directed bench for multiply_shift_add: reset, sign cases, exhaustive pairs,
// level hold, ignored mid-operation start and asynchronous reset.
module tb_multiply_shift_add;

  logic clk;
  logic rst;
  int   tests;
  int   fails;

  multiply_shift_add_if bus_if ();

  multiply_shift_add dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Capture on a fresh edge, track busy/finish/product through all four steps.
  task automatic run_op(input logic [3:0] a, input logic [3:0] b,
                        input logic [7:0] exp, input string tag);
    logic [7:0] prev;
    prev = bus_if.product;
    bus_if.first_nr           = a;
    bus_if.second_nr          = b;
    bus_if.complement1_finish = 1'b1;
    tick();
    check({tag, " busy@T"}, {7'd0, bus_if.busy}, 8'h01);
    check({tag, " fin@T"}, {7'd0, bus_if.mult_finish}, 8'h00);
    for (int i = 1; i < 4; i++) begin
      tick();
      check({tag, " busy mid"}, {7'd0, bus_if.busy}, 8'h01);
      check({tag, " hold prod"}, bus_if.product, prev);
    end
    tick();
    check({tag, " product"}, bus_if.product, exp);
    check({tag, " fin@T+4"}, {7'd0, bus_if.mult_finish}, 8'h01);
    check({tag, " busy@T+4"}, {7'd0, bus_if.busy}, 8'h00);
  endtask

  initial begin
    int         p;
    logic [7:0] exp;
    tests = 0;
    fails = 0;
    rst = 1'b0;
    bus_if.first_nr           = 4'h0;
    bus_if.second_nr          = 4'h0;
    bus_if.complement1_finish = 1'b0;
    #12;
    check("reset product", bus_if.product, 8'h00);
    check("reset finish", {7'd0, bus_if.mult_finish}, 8'h00);
    check("reset busy", {7'd0, bus_if.busy}, 8'h00);
    rst = 1'b1;
    tick();

    // 3 x 5, then hold the start level high for 20 cycles.
    run_op(4'h3, 4'h5, 8'h0F, "3x5");
    for (int i = 0; i < 20; i++) begin
      tick();
      check("hold finish", {7'd0, bus_if.mult_finish}, 8'h01);
      check("hold busy", {7'd0, bus_if.busy}, 8'h00);
      check("hold product", bus_if.product, 8'h0F);
    end
    bus_if.complement1_finish = 1'b0;
    tick();

    // Sign cases.
    run_op(4'hD, 4'h5, 8'hF1, "-3x5");
    bus_if.complement1_finish = 1'b0; tick();
    run_op(4'h7, 4'h8, 8'hC8, "7x-8");
    bus_if.complement1_finish = 1'b0; tick();
    run_op(4'h8, 4'h8, 8'h40, "-8x-8");
    bus_if.complement1_finish = 1'b0; tick();
    run_op(4'hF, 4'h0, 8'h00, "-1x0");
    bus_if.complement1_finish = 1'b0; tick();

    // Start edge during CALC with new operands must be ignored.
    bus_if.first_nr           = 4'h2;
    bus_if.second_nr          = 4'h3;
    bus_if.complement1_finish = 1'b1;
    tick();
    check("midstart busy@T", {7'd0, bus_if.busy}, 8'h01);
    bus_if.complement1_finish = 1'b0;
    tick();
    bus_if.first_nr           = 4'h5;
    bus_if.second_nr          = 4'h5;
    bus_if.complement1_finish = 1'b1;
    tick();
    tick();
    check("midstart prod held", bus_if.product, 8'h00);
    tick();
    check("midstart product", bus_if.product, 8'h06);
    check("midstart finish", {7'd0, bus_if.mult_finish}, 8'h01);
    tick();
    check("midstart no rerun", {7'd0, bus_if.busy}, 8'h00);
    check("midstart fin kept", {7'd0, bus_if.mult_finish}, 8'h01);
    bus_if.complement1_finish = 1'b0;
    tick();

    // Asynchronous reset in the middle of an operation.
    bus_if.first_nr           = 4'h7;
    bus_if.second_nr          = 4'h7;
    bus_if.complement1_finish = 1'b1;
    tick();
    tick();
    #2;
    rst = 1'b0;
    #1;
    check("rst async product", bus_if.product, 8'h00);
    check("rst async finish", {7'd0, bus_if.mult_finish}, 8'h00);
    check("rst async busy", {7'd0, bus_if.busy}, 8'h00);
    bus_if.complement1_finish = 1'b0;
    tick();
    check("rst held busy", {7'd0, bus_if.busy}, 8'h00);
    #2;
    rst = 1'b1;
    tick();
    run_op(4'h6, 4'h9, 8'hD6, "6x-7 after rst");
    bus_if.complement1_finish = 1'b0;
    tick();

    // Exhaustive: every operand pair against a signed integer reference.
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        logic [3:0] av;
        logic [3:0] bv;
        av  = a[3:0];
        bv  = b[3:0];
        p   = int'($signed(av)) * int'($signed(bv));
        exp = p[7:0];
        run_op(av, bv, exp, $sformatf("exh %h*%h", av, bv));
        bus_if.complement1_finish = 1'b0;
        tick();
        check("exh fin sticky", {7'd0, bus_if.mult_finish}, 8'h01);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/multiply_shift_add.md
# multiply_shift_add

Sequential signed 4×4 multiplier that consumes the two's-complement operands produced by the complement stage of the multiply path. It captures `first_nr`/`second_nr` on the rising edge of that stage's `complement1_finish`, then runs a 4-step shift-and-add (the last step is a subtract for the multiplier sign bit). It presents an 8-bit signed product with a sticky finish flag to the result/display stage.

## Interface

Parameters: none (widths fixed at 4-bit operands, 8-bit product).

- `clk`  in  1  system clock, rising-edge.
- `rst`  in  1  asynchronous, active-low reset. Low clears all state immediately.
- `first_nr`  in  4  multiplicand, signed two's complement. Driven by the complement stage.
- `second_nr`  in  4  multiplier, signed two's complement. Driven by the complement stage.
- `complement1_finish`  in  1  level from the complement stage. Only its 0→1 edge starts an operation.
- `product`  out  8  signed product, registered. Valid while `mult_finish` = 1.
- `mult_finish`  out  1  sticky done flag. High from result write until the next accepted start.
- `busy`  out  1  high while an operation is in progress.

## Operation

- Edge detect: a registered copy `fin_d` of `complement1_finish` is updated every cycle, including during CALC.
  - Start condition: `complement1_finish & ~fin_d`.
  - A level held high never retriggers.
- States:
  - IDLE → CALC on the start condition. Latch `M` = `first_nr` sign-extended to 8 bits and `B` = `second_nr`. Clear `acc`, set `step`=0, clear `mult_finish`, set `busy`.
  - CALC, steps 0–2: if `B[step]`, then `acc` ← `acc` + (`M` << `step`). Then `step`++.
  - CALC, step 3: if `B[3]`, then `acc` ← `acc` − (`M` << 3). Write the result to `product`, set `mult_finish`, clear `busy`, go to DONE.
  - DONE → CALC on the start condition, with the same capture actions as IDLE. Otherwise hold.
- Arithmetic is modulo 2^8. The true product range is −56…+64, so it always fits 8 bits signed and no overflow flag exists.
- A start edge arriving during CALC is ignored and is not queued. Operands are not re-sampled mid-operation.
- Input changes on `first_nr`/`second_nr` outside the capture edge have no effect.
- Reset values: `product`=8'h00, `mult_finish`=0, `busy`=0, state=IDLE, `fin_d`=0, `acc`=0, `step`=0.
  - If `complement1_finish` is already high when `rst` releases, that counts as an edge on the first clock, because `fin_d` is 0.

## Timing

- Capture edge T: the start condition is sampled high. Operands are latched, and `busy`=1 is visible after T.
- Edges T+1 … T+4 execute steps 0–3.
- After edge T+4: `product` is valid, `mult_finish`=1, `busy`=0.
- Latency is 4 cycles from capture to result. Throughput is one operation per 5 cycles minimum: the next start edge needs `complement1_finish` low for at least one cycle.
- `product` holds its previous value during CALC and changes only at the T+4 edge.
- `mult_finish` falls at a new capture edge, not before.
- Asserting `rst` at any point, including mid-CALC, asynchronously forces reset values. No partial result is written.

## Test plan

- 3 × 5: `first_nr`=4'h3, `second_nr`=4'h5, pulse `complement1_finish` 0→1 → `product`=8'h0F and `mult_finish`=1 exactly 4 cycles after the capture edge, with `busy` high for those 4 cycles.
- Sign cases, each started by a new edge:
  - −3 × 5 (4'hD, 4'h5) → 8'hF1.
  - 7 × −8 (4'h7, 4'h8) → 8'hC8.
  - −8 × −8 (4'h8, 4'h8) → 8'h40.
  - −1 × 0 (4'hF, 4'h0) → 8'h00.
- Exhaustive: all 256 operand pairs, each started by a fresh edge. Every `product` equals the signed reference product, and `mult_finish` is high only after each result.
- Level hold: keep `complement1_finish` high for 20 cycles after the first operation → exactly one operation runs, and `mult_finish` stays 1 with `product` unchanged.
- Start during CALC: a second 0→1 edge at T+2 with different operands → ignored, and the result at T+4 reflects the first operands.
- Reset mid-op: drive `rst` low at T+2 → `product`=8'h00, `mult_finish`=0, `busy`=0 immediately, without waiting for a clock. After release, a fresh edge yields a correct result.
